// File: rtl/dff_bank_arbiter_if.sv
// Bus between the requesting datapath blocks and the shared register arbiter.
// The master side drives requests and write data; the slave side returns grant and register state.
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] d_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      nq;
  logic                  busy;
  logic [IW-1:0]         last_id;

  modport master (output req, d_in, input gnt, q, nq, busy, last_id);
  modport slave  (input req, d_in, output gnt, q, nq, busy, last_id);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Each accepted write is followed by a HOLD_CYC lock-out window.
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              nrst,
  dff_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    last_id_q, last_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [WIDTH-1:0]  din [NREQ];
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       sum;
  logic              found;
  logic [IW-1:0]     pick;

  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign din[g] = bus.d_in[g*WIDTH +: WIDTH];
  end

  // Rotate requests so bit 0 is the pointer's requester, then take the first set bit.
  assign dbl = {bus.req, bus.req} >> ptr_q;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (IW+1)'(i);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        pick  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    q_d       = q_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[pick] = 1'b1;
          id_d        = pick;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Commit unconditionally: a requester dropping req mid-grant still writes.
        q_d       = din[id_q];
        last_id_d = id_q;
        ptr_d     = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        if (HOLD_CYC == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      last_id_q <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.nq      = ~q_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.last_id = last_id_q;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus randomized traffic against
// a timeline model (grant edge, write edge, next allowed sample edge).
module tb_dff_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus0 ();

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );
  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(0)) dut0 (
    .clk(clk), .nrst(nrst), .bus(bus0)
  );

  // Model of the HOLD=2 instance expressed as edge numbers rather than states.
  int               edgeNum = 0;
  int               mPtr = 0, mLast = 0, mPendId = -1, mGrantEdge = -100;
  int               mNextSample = 0, mBusyEnd = -1;
  logic [WIDTH-1:0] mQ = '0;
  logic [NREQ-1:0]  mGnt = '0;
  logic             mBusy = 1'b0;

  task automatic modelEdge();
    logic [NREQ-1:0]       r  = bus.req;
    logic [NREQ*WIDTH-1:0] dv = bus.d_in;
    bit                    got = 0;
    edgeNum++;
    mGnt = '0;
    if (!nrst) begin
      mQ = '0; mLast = 0; mPtr = 0; mPendId = -1; mBusyEnd = -1;
      mNextSample = edgeNum + 1;
    end else begin
      if (mPendId >= 0 && edgeNum == mGrantEdge + 1) begin
        mQ      = dv[mPendId*WIDTH +: WIDTH];
        mLast   = mPendId;
        mPtr    = (mPendId + 1) % NREQ;
        mPendId = -1;
      end
      if (edgeNum >= mNextSample) begin
        for (int k = 0; k < NREQ; k++) begin
          int id = (mPtr + k) % NREQ;
          if (!got && r[id]) begin
            got = 1;
            mPendId = id; mGrantEdge = edgeNum;
            mNextSample = edgeNum + 2 + HOLD;
            mBusyEnd = edgeNum + HOLD;
            mGnt[id] = 1'b1;
          end
        end
      end
    end
    mBusy = (edgeNum <= mBusyEnd);
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    bus.req  = r;
    bus.d_in = d;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    applyStimulus('1, 32'hDEAD_BEEF);
    bus0.req = '1; bus0.d_in = 32'hCAFE_F00D;
    stepClock();
    stepClock();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h want 00", bus.q); end
    checks++; if (bus.nq !== 8'hFF) begin errors++; $display("[TB] FAIL reset_nq: got %h want ff", bus.nq); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.last_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_last_id: got %0d want 0", bus.last_id); end
    checks++; if (bus0.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt_hold0: got %b want 0000", bus0.gnt); end
    bus0.req = '0;
  endtask

  task automatic test_single_write();
    int busyCount = 0;
    nrst = 1'b1;
    applyStimulus(4'b0100, 32'h11_A5_22_33);
    stepClock();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt: got %b want 0100", bus.gnt); end
    busyCount += int'(bus.busy);
    applyStimulus(4'b0000, 32'h11_A5_22_33);
    stepClock();
    busyCount += int'(bus.busy);
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_gnt_drop: got %b want 0000", bus.gnt); end
    checks++; if (bus.q !== 8'hA5) begin errors++; $display("[TB] FAIL single_q: got %h want a5", bus.q); end
    checks++; if (bus.nq !== 8'h5A) begin errors++; $display("[TB] FAIL single_nq: got %h want 5a", bus.nq); end
    checks++; if (bus.last_id !== 2'd2) begin errors++; $display("[TB] FAIL single_last_id: got %0d want 2", bus.last_id); end
    for (int i = 0; i < 3; i++) begin
      stepClock();
      busyCount += int'(bus.busy);
    end
    checks++; if (busyCount != 3) begin errors++; $display("[TB] FAIL single_busy_len: got %0d want 3", busyCount); end
  endtask

  // Pointer now sits at 3; requester 3 is idle so the search must wrap to 0, then 1.
  task automatic test_wrap_skip();
    logic [NREQ-1:0] expSeq [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    applyStimulus(4'b0011, 32'h00_00_B1_B0);
    for (int i = 0; i < 6; i++) begin
      stepClock();
      checks++; if (bus.gnt !== expSeq[i]) begin errors++; $display("[TB] FAIL wrap_gnt[%0d]: got %b want %b", i, bus.gnt, expSeq[i]); end
      if (i == 1) begin
        checks++; if (bus.q !== 8'hB0) begin errors++; $display("[TB] FAIL wrap_q0: got %h want b0", bus.q); end
      end
    end
    checks++; if (bus.q !== 8'hB1) begin errors++; $display("[TB] FAIL wrap_q1: got %h want b1", bus.q); end
  endtask

  task automatic test_back_to_back();
    int ids [$];
    int edges [$];
    int expId [5] = '{0, 1, 2, 3, 0};
    nrst = 1'b0;
    stepClock();
    nrst = 1'b1;
    applyStimulus('1, 32'h43_42_41_40);
    for (int i = 0; i < 18; i++) begin
      stepClock();
      for (int b = 0; b < NREQ; b++) begin
        if (bus.gnt[b]) begin ids.push_back(b); edges.push_back(i); end
      end
    end
    checks++; if (ids.size() != 5) begin errors++; $display("[TB] FAIL rr_count: got %0d want 5", ids.size()); end
    for (int k = 0; k < 5 && k < ids.size(); k++) begin
      checks++; if (ids[k] != expId[k]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", k, ids[k], expId[k]); end
      if (k > 0) begin
        checks++; if (edges[k] - edges[k-1] != HOLD + 2) begin errors++; $display("[TB] FAIL rr_gap[%0d]: got %0d want %0d", k, edges[k] - edges[k-1], HOLD + 2); end
      end
    end
  endtask

  task automatic test_req_drop();
    nrst = 1'b0;
    stepClock();
    nrst = 1'b1;
    applyStimulus(4'b0010, 32'h11_22_3C_44);
    stepClock();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL drop_gnt: got %b want 0010", bus.gnt); end
    applyStimulus(4'b0000, 32'h11_22_3C_44);
    stepClock();
    checks++; if (bus.q !== 8'h3C) begin errors++; $display("[TB] FAIL drop_q: got %h want 3c", bus.q); end
    checks++; if (bus.last_id !== 2'd1) begin errors++; $display("[TB] FAIL drop_last_id: got %0d want 1", bus.last_id); end
  endtask

  task automatic test_reset_mid_grant();
    nrst = 1'b0;
    stepClock();
    nrst = 1'b1;
    applyStimulus(4'b1000, 32'hEE_00_00_00);
    stepClock();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL midrst_gnt: got %b want 1000", bus.gnt); end
    nrst = 1'b0;
    stepClock();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("[TB] FAIL midrst_q: got %h want 00", bus.q); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_gnt_clr: got %b want 0000", bus.gnt); end
    nrst = 1'b1;
    applyStimulus('1, 32'hEE_00_00_00);
    stepClock();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_ptr: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_random();
    nrst = 1'b0;
    stepClock();
    for (int i = 0; i < 300; i++) begin
      nrst = ($urandom_range(0, 63) != 0);
      applyStimulus(NREQ'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom());
      stepClock();
      checks++; if (bus.gnt !== mGnt) begin errors++; $display("[TB] FAIL rand_gnt@%0d: got %b want %b", i, bus.gnt, mGnt); end
      checks++; if (bus.q !== mQ) begin errors++; $display("[TB] FAIL rand_q@%0d: got %h want %h", i, bus.q, mQ); end
      checks++; if (bus.nq !== ~mQ) begin errors++; $display("[TB] FAIL rand_nq@%0d: got %h want %h", i, bus.nq, ~mQ); end
      checks++; if (bus.busy !== mBusy) begin errors++; $display("[TB] FAIL rand_busy@%0d: got %b want %b", i, bus.busy, mBusy); end
      checks++; if (int'(bus.last_id) != mLast) begin errors++; $display("[TB] FAIL rand_last_id@%0d: got %0d want %0d", i, bus.last_id, mLast); end
      checks++; if ($countones(bus.gnt) > 1) begin errors++; $display("[TB] FAIL rand_onehot@%0d: got %b want at most one bit", i, bus.gnt); end
    end
    nrst = 1'b1;
  endtask

  // HOLD_CYC=0 instance: a permanent request is granted on every other edge.
  task automatic test_hold0();
    applyStimulus('0, '0);
    bus0.req  = 4'b0001;
    bus0.d_in = 32'h00_00_00_77;
    for (int i = 0; i < 8; i++) begin
      logic [NREQ-1:0] expG;
      expG = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      stepClock();
      checks++; if (bus0.gnt !== expG) begin errors++; $display("[TB] FAIL hold0_gnt[%0d]: got %b want %b", i, bus0.gnt, expG); end
      if (i % 2 == 1) begin
        checks++; if (bus0.q !== 8'h77) begin errors++; $display("[TB] FAIL hold0_q[%0d]: got %h want 77", i, bus0.q); end
      end
    end
    bus0.req = '0;
  endtask

  initial begin
    bus.req = '0; bus.d_in = '0; bus0.req = '0; bus0.d_in = '0;
    test_reset();
    test_single_write();
    test_wrap_skip();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_grant();
    test_random();
    test_hold0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
